mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  MEM stage of the 5-stage MIPS pipeline; consumes the EX/MEM outputs of EXECUTE.
//  Performs word loads/stores to a local data memory, resolves PCSrc for branches,
//  and registers the MEM/WB pipeline latch for the writeback stage.
//  An optional wait-state FSM models slow memory and stalls upstream stages.
// PARAMETERS
//  DEPTH_LOG2  8   log2 of data-memory depth in 32-bit words (256 words)
//  LAT         0   extra wait cycles per load/store (0..15); 0 = single-cycle memory
// PORTS
//  clk              in   1   rising-edge clock
//  reset            in   1   asynchronous, active-high reset
//  wb_ctlout        in   2   WB control from EX/MEM ({RegWrite, MemtoReg})
//  branch           in   1   branch instruction in MEM
//  memread          in   1   load request
//  memwrite         in   1   store request
//  zero             in   1   ALU zero flag
//  alu_result       in   32  byte address for loads/stores, or ALU result for WB
//  rdata2out        in   32  store data
//  five_bit_muxout  in   5   destination register number
//  PCSrc            out  1   branch taken = branch & zero (combinational)
//  mem_stall        out  1   hold IF/ID/EX and EX/MEM stable (combinational)
//  wb_ctl_wb        out  2   MEM/WB: WB control (registered)
//  read_data        out  32  MEM/WB: load data (registered)
//  mem_alu_result   out  32  MEM/WB: alu_result pass-through (registered)
//  mem_write_reg    out  5   MEM/WB: destination register (registered)
//  misaligned       out  1   only when MEM_ALIGN_CHECK_EN is defined (registered)
// BEHAVIOUR
//  - Reset: all registered outputs 0; FSM to IDLE; counter 0. Memory contents are
//    not cleared by reset; array is zero at time 0.
//  - Word index = alu_result[DEPTH_LOG2+1:2]. Upper bits are ignored (wrap-around).
//    Bits [1:0] are ignored unless MEM_ALIGN_CHECK_EN is defined.
//  - access = memread | memwrite. If both are set, the access is a store;
//    read_data captures the pre-write word.
//  - Commit edge: store writes rdata2out, load registers mem[idx] into read_data,
//    and MEM/WB captures wb_ctlout, alu_result and five_bit_muxout.
//  - Non-access cycle: MEM/WB captures inputs every edge; read_data <= 0.
//  - LAT=0: every access commits on the edge ending its cycle; mem_stall stays 0.
//  - LAT>0 FSM:
//    IDLE: mem_stall = access; on edge, if access, go to BUSY with cnt <= LAT-1.
//    BUSY: mem_stall = (cnt != 0). On edge, if cnt != 0 then cnt--;
//          otherwise commit and go to IDLE.
//  - An access therefore spans LAT+1 cycles with mem_stall high for the first LAT.
//    Inputs must be held stable throughout.
//  - Every stalled edge loads a bubble into MEM/WB (wb_ctl_wb = 0; other fields hold).
//  - Non-access instructions in IDLE pass straight through with no stall.
//  - PCSrc is independent of FSM state and stall.
//  - Reset asserted mid-BUSY: FSM goes to IDLE, no write is committed, MEM/WB is cleared.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined:
//  - An access with alu_result[1:0] != 0 suppresses the write and forces read_data = 0.
//  - The commit edge forces wb_ctl_wb = 0 and sets misaligned = 1 for one cycle.
//  - Aligned commits and non-access cycles clear misaligned.
//  MEM_ALIGN_CHECK_EN undefined: misaligned port absent; bits [1:0] are ignored.
// TESTING
//  1 Reset: reset=1 mid-run -> all outputs 0 immediately, mem_stall=0, PCSrc follows inputs.
//  2 LAT=0 store/load:
//    - sw 0xDEADBEEF to addr 0x10, then lw addr 0x10 with wb_ctlout=2'b11, rd=5'd9
//      -> next edge read_data=0xDEADBEEF, wb_ctl_wb=2'b11, mem_write_reg=9.
//  3 Branch: branch=1, zero=1 -> PCSrc=1 same cycle; branch=1, zero=0 -> PCSrc=0.
//  4 LAT=2 load:
//    - mem_stall=1 for 2 cycles with a bubble (wb_ctl_wb=0) in MEM/WB.
//    - 3rd edge commits read_data; a following add passes with no stall.
//  5 Wrap and overlap:
//    - sw 0x12345678 to addr 0x400 (DEPTH_LOG2=8) -> lw addr 0x0 returns 0x12345678.
//    - memread=memwrite=1 -> old word read, new word stored.
//  6 Mid-access reset (LAT=3): reset in BUSY before commit -> subsequent lw of that
//    address returns the old value. Misaligned (macro on): sw to addr 0x13 -> no write,
//    misaligned=1 for 1 cycle, wb_ctl_wb=0.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: local word data memory, branch resolution,
// optional wait-state FSM (LAT>0) and MEM/WB latch. Optional feature macro: MEM_ALIGN_CHECK_EN.
module mem_stage #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LAT        = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  wb_ctlout,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2out,
  input  logic [4:0]  five_bit_muxout,
  output logic        PCSrc,
  output logic        mem_stall,
  output logic [1:0]  wb_ctl_wb,
  output logic [31:0] read_data,
  output logic [31:0] mem_alu_result,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        misaligned,
`endif
  output logic [4:0]  mem_write_reg
);

  localparam int          DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0]  LAT_M1 = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  // Handshake: while mem_stall is high the upstream stages must hold the EX/MEM
  // inputs stable; the access commits on the first edge with mem_stall low.
  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        access;
  logic        stall;
  logic        commit;
  logic        align_ok;

  logic [31:0]           mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           rd_word;

  assign access  = memread | memwrite;
  assign idx     = alu_result[DEPTH_LOG2+1:2];
  assign rd_word = mem[idx];

  assign PCSrc     = branch & zero;
  assign mem_stall = stall & ~reset;

`ifdef MEM_ALIGN_CHECK_EN
  assign align_ok = (alu_result[1:0] == 2'b00);
`else
  assign align_ok = 1'b1;
`endif

  // Address bits outside the word index only matter for the alignment check.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{alu_result[31:DEPTH_LOG2+2], alu_result[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (LAT == 0) begin
            commit = 1'b1;
          end else begin
            stall     = 1'b1;
            state_nxt = BUSY;
            cnt_nxt   = LAT_M1;
          end
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          stall   = 1'b1;
          cnt_nxt = cnt - 4'd1;
        end else begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Memory is deliberately outside reset; a reset edge never commits a store.
  always_ff @(posedge clk) begin
    if (commit && memwrite && align_ok && !reset) begin
      mem[idx] <= rdata2out;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_ctl_wb      <= 2'b00;
      read_data      <= 32'd0;
      mem_alu_result <= 32'd0;
      mem_write_reg  <= 5'd0;
    end else if (stall) begin
      wb_ctl_wb <= 2'b00;
    end else begin
      mem_alu_result <= alu_result;
      mem_write_reg  <= five_bit_muxout;
      if (commit) begin
        wb_ctl_wb <= align_ok ? wb_ctlout : 2'b00;
        read_data <= (memread && align_ok) ? rd_word : 32'd0;
      end else begin
        wb_ctl_wb <= wb_ctlout;
        read_data <= 32'd0;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misaligned <= 1'b0;
    end else if (!stall) begin
      misaligned <= commit && !align_ok;
    end
  end
`endif

endmodule
